// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-channel TDM link: deserialises MSB-first W-bit slots,
// steers each finished word to its channel register and tracks frame lock.
module tdm_demux_4ch #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         valid,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         ch_stb,
  output logic [1:0]   ch_id,
  output logic         frame_done,
  output logic         sync_err,
  output logic         locked
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   bit_cnt_r;
  logic [1:0]      slot_r;
  // Only the low W-1 bits of the shifter are ever read back, so that is all we keep.
  logic [W-2:0]    sh_r;
  logic [W-1:0]    y_r [4];
  logic            ch_stb_r;
  logic [1:0]      ch_id_r;
  logic            frame_done_r;
  logic            sync_err_r;
  logic            locked_r;

  logic            boundary_s;
  logic [W-1:0]    word_s;
  logic [W-2:0]    restart_s;

  // Frame-boundary detection and the word formed by the current bit.
  always_comb begin
    boundary_s   = (bit_cnt_r == CNT_ZERO) && (slot_r == 2'd0);
    word_s       = {sh_r, din};
    restart_s    = {(W-1){1'b0}};
    restart_s[0] = din;
  end

  // Lock FSM, slot/bit counters, shifter and channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= HUNT;
      bit_cnt_r    <= CNT_ZERO;
      slot_r       <= 2'd0;
      sh_r         <= {(W-1){1'b0}};
      for (int k = 0; k < 4; k++) y_r[k] <= {W{1'b0}};
      ch_stb_r     <= 1'b0;
      ch_id_r      <= 2'd0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      ch_stb_r     <= 1'b0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      if (valid) begin
        case (state_r)
          HUNT: begin
            if (sync) begin
              state_r   <= RECV;
              locked_r  <= 1'b1;
              sh_r      <= restart_s;
              bit_cnt_r <= CNT_ONE;
              slot_r    <= 2'd0;
            end
          end
          RECV: begin
            if (sync && !boundary_s) begin
              // Early sync: drop the partial frame and restart on this bit.
              sync_err_r <= 1'b1;
              sh_r       <= restart_s;
              bit_cnt_r  <= CNT_ONE;
              slot_r     <= 2'd0;
            end else if (!sync && boundary_s) begin
              sync_err_r <= 1'b1;
              state_r    <= HUNT;
              locked_r   <= 1'b0;
            end else begin
              sh_r <= word_s[W-2:0];
              if (bit_cnt_r == CNT_LAST) begin
                y_r[slot_r]  <= word_s;
                ch_stb_r     <= 1'b1;
                ch_id_r      <= slot_r;
                frame_done_r <= (slot_r == 2'd3);
                bit_cnt_r    <= CNT_ZERO;
                slot_r       <= slot_r + 2'd1;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end
          end
          default: begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign y0         = y_r[0];
  assign y1         = y_r[1];
  assign y2         = y_r[2];
  assign y3         = y_r[3];
  assign ch_stb     = ch_stb_r;
  assign ch_id      = ch_id_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed self-checking bench for tdm_demux_4ch with W=4.
module tb_tdm_demux_4ch;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         valid;
  logic         sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         ch_stb;
  logic [1:0]   ch_id;
  logic         frame_done;
  logic         sync_err;
  logic         locked;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tdm_demux_4ch #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .valid(valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .ch_stb(ch_stb), .ch_id(ch_id), .frame_done(frame_done),
    .sync_err(sync_err), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present one input cycle and return 1 time unit after the sampling edge.
  task automatic send(input logic d, input logic s, input logic v);
    din = d; sync = s; valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; din = 1'b0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({y0, y1, y2, y3} !== 16'h0000) begin
      failures++; $display("FAIL reset_y got=%h exp=0000", {y0, y1, y2, y3});
    end
    checks++;
    if ({locked, ch_stb, frame_done, sync_err, ch_id} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {locked, ch_stb, frame_done, sync_err, ch_id});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_sync();
    for (int i = 0; i < 8; i++) begin
      send(i[0], 1'b0, 1'b1);
      checks++;
      if ({locked, ch_stb, frame_done, sync_err} !== 4'b0) begin
        failures++; $display("FAIL nosync_flags i=%0d got=%b exp=0000", i, {locked, ch_stb, frame_done, sync_err});
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'h0000) begin
      failures++; $display("FAIL nosync_y got=%h exp=0000", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] f;
    f = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      send(f[15-i], (i == 0), 1'b1);
      checks++;
      if (locked !== 1'b1) begin
        failures++; $display("FAIL single_locked i=%0d got=%b exp=1", i, locked);
      end
      checks++;
      if (ch_stb !== ((i % 4) == 3)) begin
        failures++; $display("FAIL single_stb i=%0d got=%b exp=%b", i, ch_stb, ((i % 4) == 3));
      end
      if ((i % 4) == 3) begin
        checks++;
        if (ch_id !== 2'(i / 4)) begin
          failures++; $display("FAIL single_id i=%0d got=%0d exp=%0d", i, ch_id, i / 4);
        end
      end
      checks++;
      if (frame_done !== (i == 15)) begin
        failures++; $display("FAIL single_fd i=%0d got=%b exp=%b", i, frame_done, (i == 15));
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'hA5C3) begin
      failures++; $display("FAIL single_y got=%h exp=a5c3", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_valid_gaps();
    logic [15:0] f;
    f = 16'hA5C3;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 12) begin
        for (int g = 0; g < 3; g++) begin
          send(1'b1, 1'b1, 1'b0);
          checks++;
          if ({locked, ch_stb, frame_done, sync_err} !== 4'b1000) begin
            failures++; $display("FAIL gap_idle i=%0d got=%b exp=1000", i, {locked, ch_stb, frame_done, sync_err});
          end
        end
      end
      send(f[15-i], (i == 0), 1'b1);
      checks++;
      if ({ch_stb, frame_done, sync_err} !== {((i % 4) == 3), (i == 15), 1'b0}) begin
        failures++; $display("FAIL gap_pulses i=%0d got=%b exp=%b", i, {ch_stb, frame_done, sync_err}, {((i % 4) == 3), (i == 15), 1'b0});
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'hA5C3) begin
      failures++; $display("FAIL gap_y got=%h exp=a5c3", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    int fd [2];
    int n;
    s = 32'hA5C3_F096;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      send(s[31-i], ((i % 16) == 0), 1'b1);
      if (frame_done === 1'b1 && n < 2) begin
        fd[n] = cyc;
        n++;
      end
      checks++;
      if (sync_err !== 1'b0) begin
        failures++; $display("FAIL b2b_err i=%0d got=%b exp=0", i, sync_err);
      end
    end
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL b2b_fd_count got=%0d exp=2", n);
    end else begin
      checks++;
      if (fd[1] - fd[0] !== 16) begin
        failures++; $display("FAIL b2b_fd_spacing got=%0d exp=16", fd[1] - fd[0]);
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'hF096) begin
      failures++; $display("FAIL b2b_y got=%h exp=f096", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_missing_sync();
    send(1'b1, 1'b0, 1'b1);
    checks++;
    if ({sync_err, locked, ch_stb} !== 3'b100) begin
      failures++; $display("FAIL miss_flags got=%b exp=100", {sync_err, locked, ch_stb});
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'hF096) begin
      failures++; $display("FAIL miss_y got=%h exp=f096", {y0, y1, y2, y3});
    end
    send(1'b0, 1'b0, 1'b0);
    checks++;
    if ({sync_err, locked} !== 2'b00) begin
      failures++; $display("FAIL miss_pulse_width got=%b exp=00", {sync_err, locked});
    end
    send(1'b1, 1'b0, 1'b1);
    checks++;
    if ({sync_err, locked} !== 2'b00) begin
      failures++; $display("FAIL miss_hunt got=%b exp=00", {sync_err, locked});
    end
  endtask

  task automatic test_mid_sync();
    logic [15:0] f1;
    logic [15:0] f2;
    f1 = 16'hA5C3;
    f2 = 16'h6E1B;
    for (int i = 0; i < 9; i++) send(f1[15-i], (i == 0), 1'b1);
    checks++;
    if ({y0, y1, y2, y3} !== 16'hA596) begin
      failures++; $display("FAIL mid_pre_y got=%h exp=a596", {y0, y1, y2, y3});
    end
    send(f2[15], 1'b1, 1'b1);
    checks++;
    if ({sync_err, locked, ch_stb} !== 3'b110) begin
      failures++; $display("FAIL mid_flags got=%b exp=110", {sync_err, locked, ch_stb});
    end
    for (int j = 1; j < 16; j++) begin
      send(f2[15-j], 1'b0, 1'b1);
      checks++;
      if ({ch_stb, sync_err} !== {((j % 4) == 3), 1'b0}) begin
        failures++; $display("FAIL mid_pulses j=%0d got=%b exp=%b", j, {ch_stb, sync_err}, {((j % 4) == 3), 1'b0});
      end
      if (j == 3) begin
        checks++;
        if ({y0, y2} !== 8'h69) begin
          failures++; $display("FAIL mid_restart_y got=%h exp=69", {y0, y2});
        end
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'h6E1B) begin
      failures++; $display("FAIL mid_y got=%h exp=6e1b", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] f;
    f = 16'h1234;
    for (int i = 0; i < 6; i++) send(f[15-i], (i == 0), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y0, y1, y2, y3} !== 16'h0000) begin
      failures++; $display("FAIL rstmid_y got=%h exp=0000", {y0, y1, y2, y3});
    end
    checks++;
    if ({locked, ch_stb, frame_done, sync_err, ch_id} !== 6'b0) begin
      failures++; $display("FAIL rstmid_flags got=%b exp=000000", {locked, ch_stb, frame_done, sync_err, ch_id});
    end
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    f = 16'h8E7D;
    for (int i = 0; i < 16; i++) begin
      send(f[15-i], (i == 0), 1'b1);
      checks++;
      if (frame_done !== (i == 15)) begin
        failures++; $display("FAIL rstmid_fd i=%0d got=%b exp=%b", i, frame_done, (i == 15));
      end
    end
    checks++;
    if ({y0, y1, y2, y3} !== 16'h8E7D) begin
      failures++; $display("FAIL rstmid_after_y got=%h exp=8e7d", {y0, y1, y2, y3});
    end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_single_frame();
    test_valid_gaps();
    test_back_to_back();
    test_missing_sync();
    test_mid_sync();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
